// File: rtl/rf_wport_arbiter.sv
// Shares the register-file write port between pipeline writeback and a queued
// multi-cycle result source, with a pending-register scoreboard and anti-starvation stall.
module rf_wport_arbiter #(
  parameter int DEPTH  = 2,
  parameter int STARVE = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        WB_wen,
  input  logic [4:0]  WB_rd,
  input  logic [31:0] WB_wdata,
  input  logic        MD_valid,
  output logic        MD_ready,
  input  logic [4:0]  MD_rd,
  input  logic [31:0] MD_wdata,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic [4:0]  ID_dst,
  output logic        ID_stall,
  output logic        WB_stall,
  output logic        RF_wen,
  output logic [4:0]  RF_rd,
  output logic [31:0] RF_wdata
);

  localparam logic [2:0] FULL_COUNT = 3'(DEPTH);
  localparam logic [1:0] LAST_SLOT  = 2'(DEPTH - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE);

  // Storage is sized for the largest legal DEPTH so slot pointers index it exactly.
  logic [4:0]  fifo_rd   [4];
  logic [31:0] fifo_data [4];

  logic [1:0]  head;
  logic [1:0]  tail;
  logic [2:0]  count;
  logic [31:0] pend;
  logic [31:0] pend_next;
  logic [3:0]  starve_cnt;
  logic [3:0]  starve_cnt_next;
  logic        wb_stall_q;

  logic        wb_valid;
  logic        fifo_empty;
  logic        fifo_full;
  logic        drain;
  logic        md_accept;
  logic        push;

  function automatic logic [1:0] next_slot(input logic [1:0] slot);
    return (slot == LAST_SLOT) ? 2'd0 : slot + 2'd1;
  endfunction

  always_comb begin
    wb_valid   = WB_wen && (WB_rd != 5'd0);
    fifo_empty = (count == 3'd0);
    fifo_full  = (count == FULL_COUNT);
    drain      = rst_n && !wb_valid && !fifo_empty;
    MD_ready   = rst_n && !fifo_full && !pend[MD_rd];
    md_accept  = MD_valid && MD_ready;
    push       = md_accept && (MD_rd != 5'd0);
  end

  always_comb begin
    RF_wen   = 1'b0;
    RF_rd    = 5'd0;
    RF_wdata = 32'd0;
    if (rst_n) begin
      if (wb_valid) begin
        RF_wen   = 1'b1;
        RF_rd    = WB_rd;
        RF_wdata = WB_wdata;
      end else if (!fifo_empty) begin
        RF_wen   = 1'b1;
        RF_rd    = fifo_rd[head];
        RF_wdata = fifo_data[head];
      end
    end
  end

  // A push never targets the draining register, since a pending rd blocks MD_ready.
  always_comb begin
    pend_next = pend;
    if (drain) begin
      pend_next[fifo_rd[head]] = 1'b0;
    end
    if (push) begin
      pend_next[MD_rd] = 1'b1;
    end
    pend_next[0] = 1'b0;
  end

  always_comb begin
    starve_cnt_next = starve_cnt;
    if (fifo_empty || drain) begin
      starve_cnt_next = 4'd0;
    end else if (starve_cnt < STARVE_MAX) begin
      starve_cnt_next = starve_cnt + 4'd1;
    end
  end

  always_comb begin
    ID_stall = rst_n && (pend[ID_rs] || pend[ID_rt] || pend[ID_dst]);
    WB_stall = wb_stall_q;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[tail]   <= MD_rd;
      fifo_data[tail] <= MD_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head       <= 2'd0;
      tail       <= 2'd0;
      count      <= 3'd0;
      pend       <= 32'd0;
      starve_cnt <= 4'd0;
      wb_stall_q <= 1'b0;
    end else begin
      if (push) begin
        tail <= next_slot(tail);
      end
      if (drain) begin
        head <= next_slot(head);
      end
      case ({push, drain})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      pend       <= pend_next;
      starve_cnt <= starve_cnt_next;
      // Held while the pipeline ignores it; only an actual drain releases it.
      if (drain) begin
        wb_stall_q <= 1'b0;
      end else if (starve_cnt_next == STARVE_MAX) begin
        wb_stall_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench for rf_wport_arbiter: reset, WB priority, scoreboard,
// backpressure, starvation and rd=0 cases with hand-computed expectations.
module tb_rf_wport_arbiter;

  logic        clk;
  logic        rst_n;
  logic        WB_wen;
  logic [4:0]  WB_rd;
  logic [31:0] WB_wdata;
  logic        MD_valid;
  logic        MD_ready;
  logic [4:0]  MD_rd;
  logic [31:0] MD_wdata;
  logic [4:0]  ID_rs;
  logic [4:0]  ID_rt;
  logic [4:0]  ID_dst;
  logic        ID_stall;
  logic        WB_stall;
  logic        RF_wen;
  logic [4:0]  RF_rd;
  logic [31:0] RF_wdata;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] WBD = 32'h00030000;

  rf_wport_arbiter #(.DEPTH(2), .STARVE(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .WB_wen   (WB_wen),
    .WB_rd    (WB_rd),
    .WB_wdata (WB_wdata),
    .MD_valid (MD_valid),
    .MD_ready (MD_ready),
    .MD_rd    (MD_rd),
    .MD_wdata (MD_wdata),
    .ID_rs    (ID_rs),
    .ID_rt    (ID_rt),
    .ID_dst   (ID_dst),
    .ID_stall (ID_stall),
    .WB_stall (WB_stall),
    .RF_wen   (RF_wen),
    .RF_rd    (RF_rd),
    .RF_wdata (RF_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic wen, input logic [4:0] wrd, input logic [31:0] wdat,
                                input logic mv, input logic [4:0] mrd, input logic [31:0] mdat);
    WB_wen   = wen;
    WB_rd    = wrd;
    WB_wdata = wdat;
    MD_valid = mv;
    MD_rd    = mrd;
    MD_wdata = mdat;
    #1;
  endtask

  task automatic set_decode(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst);
    ID_rs  = rs;
    ID_rt  = rt;
    ID_dst = dst;
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    check_output(tag, {31'd0, obs}, {31'd0, exp});
  endtask

  task automatic check_rf(input string tag, input logic wen, input logic [4:0] rd, input logic [31:0] data);
    check_output({tag, "_wen"}, {31'd0, RF_wen}, {31'd0, wen});
    check_output({tag, "_rd"}, {27'd0, RF_rd}, {27'd0, rd});
    check_output({tag, "_wdata"}, RF_wdata, data);
  endtask

  initial begin
    rst_n = 1'b1;
    WB_wen = 1'b1; WB_rd = 5'd3; WB_wdata = WBD;
    MD_valid = 1'b1; MD_rd = 5'd5; MD_wdata = 32'h55;
    ID_rs = 5'd5; ID_rt = 5'd0; ID_dst = 5'd0;
    #1 rst_n = 1'b0;
    #1;
    check_rf("in_reset", 1'b0, 5'd0, 32'd0);
    check_bit("in_reset_md_ready", MD_ready, 1'b0);
    check_bit("in_reset_id_stall", ID_stall, 1'b0);
    check_bit("in_reset_wb_stall", WB_stall, 1'b0);
    next_cycle();
    next_cycle();
    apply_stimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    set_decode(5'd0, 5'd0, 5'd0);
    rst_n = 1'b1;
    #1;
    check_rf("after_reset_idle", 1'b0, 5'd0, 32'd0);
    check_bit("after_reset_md_ready", MD_ready, 1'b1);

    // Reset while two MD results are queued
    next_cycle();
    apply_stimulus(1'b1, 5'd3, WBD, 1'b1, 5'd5, 32'h55550005);
    check_bit("push_r5_ready", MD_ready, 1'b1);
    next_cycle();
    apply_stimulus(1'b1, 5'd3, WBD, 1'b1, 5'd6, 32'h66660006);
    check_bit("push_r6_ready", MD_ready, 1'b1);
    check_rf("wb_over_queue", 1'b1, 5'd3, WBD);
    next_cycle();
    apply_stimulus(1'b1, 5'd3, WBD, 1'b1, 5'd7, 32'h77);
    set_decode(5'd5, 5'd6, 5'd0);
    check_bit("full_not_ready", MD_ready, 1'b0);
    check_bit("pend_r5_stall", ID_stall, 1'b1);
    rst_n = 1'b0;
    #1;
    check_bit("mid_reset_stall", ID_stall, 1'b0);
    check_bit("mid_reset_rf_wen", RF_wen, 1'b0);
    check_bit("mid_reset_md_ready", MD_ready, 1'b0);
    next_cycle();
    apply_stimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 32'd0);
    rst_n = 1'b1;
    #1;
    check_bit("released_ready", MD_ready, 1'b1);
    check_bit("released_no_stall", ID_stall, 1'b0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      check_rf("no_stale_write", 1'b0, 5'd0, 32'd0);
    end
    set_decode(5'd0, 5'd0, 5'd0);

    // Writeback keeps priority; queued r9 waits for an idle slot
    next_cycle();
    apply_stimulus(1'b1, 5'd3, WBD, 1'b1, 5'd9, 32'hDEAD0009);
    check_bit("r9_ready", MD_ready, 1'b1);
    check_rf("wb_prio_push", 1'b1, 5'd3, WBD);
    next_cycle();
    apply_stimulus(1'b1, 5'd3, WBD, 1'b0, 5'd0, 32'd0);
    check_rf("wb_prio_hold1", 1'b1, 5'd3, WBD);
    next_cycle();
    check_rf("wb_prio_hold2", 1'b1, 5'd3, WBD);
    next_cycle();
    apply_stimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check_rf("r9_drain", 1'b1, 5'd9, 32'hDEAD0009);
    next_cycle();
    check_rf("after_r9", 1'b0, 5'd0, 32'd0);

    // Scoreboard on r7
    next_cycle();
    apply_stimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77770007);
    set_decode(5'd7, 5'd0, 5'd0);
    check_bit("r7_ready", MD_ready, 1'b1);
    check_bit("r7_not_yet_pending", ID_stall, 1'b0);
    check_rf("push_empty_no_drain", 1'b0, 5'd0, 32'd0);
    next_cycle();
    apply_stimulus(1'b1, 5'd3, WBD, 1'b0, 5'd0, 32'd0);
    check_bit("r7_stall_queued", ID_stall, 1'b1);
    check_rf("r7_blocked_by_wb", 1'b1, 5'd3, WBD);
    next_cycle();
    apply_stimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check_bit("r7_stall_drain_cycle", ID_stall, 1'b1);
    check_rf("r7_drain", 1'b1, 5'd7, 32'h77770007);
    next_cycle();
    check_bit("r7_stall_released", ID_stall, 1'b0);
    check_rf("after_r7", 1'b0, 5'd0, 32'd0);
    set_decode(5'd0, 5'd0, 5'd0);

    // Backpressure: pending rd and full FIFO
    next_cycle();
    apply_stimulus(1'b1, 5'd3, WBD, 1'b1, 5'd1, 32'h11110001);
    check_bit("r1_ready", MD_ready, 1'b1);
    next_cycle();
    apply_stimulus(1'b1, 5'd3, WBD, 1'b1, 5'd1, 32'h11110001);
    check_bit("r1_pending_not_ready", MD_ready, 1'b0);
    apply_stimulus(1'b1, 5'd3, WBD, 1'b1, 5'd2, 32'h22220002);
    check_bit("r2_ready", MD_ready, 1'b1);
    next_cycle();
    apply_stimulus(1'b1, 5'd3, WBD, 1'b1, 5'd10, 32'h0A);
    check_bit("full_blocks_r10", MD_ready, 1'b0);
    set_decode(5'd0, 5'd2, 5'd0);
    check_bit("rt_pending_stall", ID_stall, 1'b1);
    set_decode(5'd0, 5'd0, 5'd1);
    check_bit("dst_pending_stall", ID_stall, 1'b1);
    set_decode(5'd0, 5'd0, 5'd0);
    check_bit("r0_never_stalls", ID_stall, 1'b0);
    next_cycle();
    apply_stimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd10, 32'd0);
    check_bit("still_full_during_drain", MD_ready, 1'b0);
    check_rf("r1_drain", 1'b1, 5'd1, 32'h11110001);
    next_cycle();
    apply_stimulus(1'b1, 5'd3, WBD, 1'b0, 5'd10, 32'd0);
    check_bit("ready_after_pop", MD_ready, 1'b1);
    next_cycle();
    apply_stimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check_rf("r2_drain", 1'b1, 5'd2, 32'h22220002);
    next_cycle();
    check_rf("after_r2", 1'b0, 5'd0, 32'd0);

    // Starvation with a compliant pipeline
    next_cycle();
    apply_stimulus(1'b1, 5'd3, WBD, 1'b1, 5'd4, 32'h44440004);
    check_bit("starve_start", WB_stall, 1'b0);
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      apply_stimulus(1'b1, 5'd3, WBD, 1'b0, 5'd0, 32'd0);
      check_bit("starve_wait", WB_stall, 1'b0);
    end
    next_cycle();
    apply_stimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check_bit("starve_stall", WB_stall, 1'b1);
    check_rf("r4_forced_drain", 1'b1, 5'd4, 32'h44440004);
    next_cycle();
    check_bit("starve_cleared", WB_stall, 1'b0);
    check_rf("after_r4", 1'b0, 5'd0, 32'd0);

    // Starvation with a pipeline that ignores WB_stall
    next_cycle();
    apply_stimulus(1'b1, 5'd3, WBD, 1'b1, 5'd4, 32'h44440044);
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      apply_stimulus(1'b1, 5'd3, WBD, 1'b0, 5'd0, 32'd0);
    end
    next_cycle();
    check_bit("violate_stall1", WB_stall, 1'b1);
    check_rf("violate_wb_wins", 1'b1, 5'd3, WBD);
    next_cycle();
    check_bit("violate_stall2", WB_stall, 1'b1);
    next_cycle();
    apply_stimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check_bit("violate_stall3", WB_stall, 1'b1);
    check_rf("violate_late_drain", 1'b1, 5'd4, 32'h44440044);
    next_cycle();
    check_bit("violate_cleared", WB_stall, 1'b0);

    // rd=0 on both sources, plus simultaneous push and drain
    next_cycle();
    apply_stimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h00000BAD);
    check_bit("md_rd0_ready", MD_ready, 1'b1);
    next_cycle();
    apply_stimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check_rf("md_rd0_discarded", 1'b0, 5'd0, 32'd0);
    check_bit("md_rd0_no_stall", ID_stall, 1'b0);
    next_cycle();
    apply_stimulus(1'b1, 5'd3, WBD, 1'b1, 5'd8, 32'h88880008);
    check_bit("r8_ready", MD_ready, 1'b1);
    next_cycle();
    apply_stimulus(1'b1, 5'd0, 32'h12345678, 1'b1, 5'd13, 32'h0D0D000D);
    check_bit("r13_ready", MD_ready, 1'b1);
    check_rf("wb_rd0_drains_r8", 1'b1, 5'd8, 32'h88880008);
    next_cycle();
    apply_stimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check_rf("push_drain_order", 1'b1, 5'd13, 32'h0D0D000D);
    next_cycle();
    check_rf("final_idle", 1'b0, 5'd0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
